systolic_controller: RTL and testbench

- Job-level sequencer for the 2x2 systolic tile.
- On a start request it clears the activation skew stage, pulses weight load, and holds the skew stage's valid for the skewed feed window.
- It then waits out the array pipeline, pulses output capture and reports completion.
- Sits between the host/command interface and the input skew stage, weight registers and output registers of the array.

---
 rtl/systolic_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_systolic_controller.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_controller.sv
// ============================================================================
// systolic_controller
// ----------------------------------------------------------------------------
// Job-level sequencer for the 2x2 systolic tile. A job runs through these
// steps:
//   1. clear the activation skew stage;
//   2. pulse the weight load;
//   3. hold the skew stage's valid for the skewed feed window;
//   4. wait out the array pipeline;
//   5. pulse the output capture;
//   6. report completion.
//
// Parameters
//   N             array dimension; the feed window is 2*N-1 cycles
//   DRAIN_CYCLES  cycles between the last feed cycle and capture (1..255)
//   CNT_W         width of the phase counter and of jobs_done
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        asynchronous, active-high; clears all state
//   start        job request, sampled in IDLE and DONE only
//   abort        cancels an in-flight job, sampled in busy states only
//   setup_clear  one-cycle pulse zeroing the skew stage's counter and rows
//   load_weight  one-cycle pulse latching weights into the PEs
//   setup_valid  high for exactly FEED_CYCLES consecutive cycles per job
//   capture      one-cycle pulse latching the array outputs
//   busy         high in CLEAR, LOAD_W, FEED, DRAIN, CAPTURE
//   done         one-cycle pulse on job completion
//   aborted      one-cycle pulse the cycle after an accepted abort
//   state        current state encoding, for debug
//   jobs_done    completed-job count, wraps modulo 2^CNT_W
// ============================================================================
module systolic_controller #(
    parameter int N            = 2,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             setup_clear,
    output logic             load_weight,
    output logic             setup_valid,
    output logic             capture,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] jobs_done
);

    // The skewed feed of an N-row array needs 2*N-1 cycles; this is derived
    // from N and deliberately not a separate parameter.
    localparam int FEED_CYCLES = 2 * N - 1;

    // Terminal counts for the two multi-cycle phases.
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_LOAD_W  = 3'd2,
        S_FEED    = 3'd3,
        S_DRAIN   = 3'd4,
        S_CAPTURE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  jobs_reg;
    logic [CNT_W-1:0]  jobs_next;
    logic              aborted_reg;
    logic              aborted_next;
    logic              in_busy_state;

    // CLEAR through CAPTURE are the states in which a job is in flight and
    // abort is honoured. IDLE, DONE and the unused code 7 fall outside.
    assign in_busy_state = (state_reg >= S_CLEAR) && (state_reg <= S_CAPTURE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            jobs_reg    <= '0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            jobs_reg    <= jobs_next;
            aborted_reg <= aborted_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        jobs_next    = jobs_reg;
        aborted_next = 1'b0;

        if (in_busy_state && abort) begin
            // Abort wins over every normal transition, including
            // CAPTURE->DONE, so an aborted job is never counted.
            state_next   = S_IDLE;
            cnt_next     = '0;
            aborted_next = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    cnt_next = '0;
                    if (start) begin
                        state_next = S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    state_next = S_LOAD_W;
                end

                S_LOAD_W: begin
                    state_next = S_FEED;
                    cnt_next   = '0;
                end

                S_FEED: begin
                    if (cnt_reg == FEED_LAST) begin
                        state_next = S_DRAIN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end

                S_DRAIN: begin
                    if (cnt_reg == DRAIN_LAST) begin
                        state_next = S_CAPTURE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end

                S_CAPTURE: begin
                    state_next = S_DONE;
                    // Count the job as soon as its results are latched;
                    // the new value is visible alongside the done pulse.
                    jobs_next  = jobs_reg + CNT_ONE;
                end

                S_DONE: begin
                    // A start seen in DONE chains the next job directly,
                    // skipping IDLE. abort has no meaning here.
                    if (start) begin
                        state_next = S_CLEAR;
                    end else begin
                        state_next = S_IDLE;
                    end
                end

                default: begin
                    // Unused code 7: fall back to a clean idle state.
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode (Moore, from the state register only)
    // ------------------------------------------------------------------
    always_comb begin
        setup_clear = 1'b0;
        load_weight = 1'b0;
        setup_valid = 1'b0;
        capture     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_reg)
            S_CLEAR: begin
                setup_clear = 1'b1;
                busy        = 1'b1;
            end
            S_LOAD_W: begin
                load_weight = 1'b1;
                busy        = 1'b1;
            end
            S_FEED: begin
                setup_valid = 1'b1;
                busy        = 1'b1;
            end
            S_DRAIN: begin
                busy        = 1'b1;
            end
            S_CAPTURE: begin
                capture     = 1'b1;
                busy        = 1'b1;
            end
            S_DONE: begin
                done        = 1'b1;
            end
            default: begin
                // IDLE and the unused code keep every strobe low.
            end
        endcase
    end

    assign aborted   = aborted_reg;
    assign jobs_done = jobs_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_systolic_controller.sv
module tb_systolic_controller;

    localparam int F = 3;   // feed window for N=2

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic abort;

    logic       sc  [3];
    logic       lw  [3];
    logic       sv  [3];
    logic       cap [3];
    logic       bsy [3];
    logic       dn  [3];
    logic       ab  [3];
    logic [2:0] st  [3];
    logic [7:0] jd0;
    logic [1:0] jd1;
    logic [7:0] jd2;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance 0: defaults. Instance 1: CNT_W=2. Instance 2: DRAIN_CYCLES=1.
    systolic_controller u0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .setup_clear(sc[0]), .load_weight(lw[0]), .setup_valid(sv[0]),
        .capture(cap[0]), .busy(bsy[0]), .done(dn[0]), .aborted(ab[0]),
        .state(st[0]), .jobs_done(jd0)
    );

    systolic_controller #(.CNT_W(2)) u1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .setup_clear(sc[1]), .load_weight(lw[1]), .setup_valid(sv[1]),
        .capture(cap[1]), .busy(bsy[1]), .done(dn[1]), .aborted(ab[1]),
        .state(st[1]), .jobs_done(jd1)
    );

    systolic_controller #(.DRAIN_CYCLES(1)) u2 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .setup_clear(sc[2]), .load_weight(lw[2]), .setup_valid(sv[2]),
        .capture(cap[2]), .busy(bsy[2]), .done(dn[2]), .aborted(ab[2]),
        .state(st[2]), .jobs_done(jd2)
    );

    // ------------------------------------------------------------------
    // Reference model: a job is tracked only by its age (cycles since the
    // accepting edge); every output is a function of that age.
    // ------------------------------------------------------------------
    int age  [3];
    int jobs [3];
    bit abt  [3];

    function automatic int drain_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic int jmask(input int i);
        return (i == 1) ? 3 : 255;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            age[i]  = 0;
            jobs[i] = 0;
            abt[i]  = 1'b0;
        end
    endfunction

    function automatic void model_update(input logic s, input logic a);
        for (int i = 0; i < 3; i++) begin
            int last_busy;
            last_busy = 3 + F + drain_of(i);   // age of the capture cycle
            if (age[i] >= 1 && age[i] <= last_busy) begin
                if (a) begin
                    age[i] = 0;
                    abt[i] = 1'b1;
                end else begin
                    if (age[i] == last_busy) jobs[i] = jobs[i] + 1;
                    age[i] = age[i] + 1;
                    abt[i] = 1'b0;
                end
            end else begin
                abt[i] = 1'b0;
                age[i] = s ? 1 : 0;
            end
        end
    endfunction

    function automatic logic [17:0] exp_vec(input int i);
        int d, a;
        logic e_sc, e_lw, e_sv, e_cap, e_bsy, e_dn;
        logic [2:0] e_st;
        logic [7:0] e_jd;
        d = drain_of(i);
        a = age[i];
        e_sc  = (a == 1);
        e_lw  = (a == 2);
        e_sv  = (a >= 3) && (a <= 2 + F);
        e_cap = (a == 3 + F + d);
        e_bsy = (a >= 1) && (a <= 3 + F + d);
        e_dn  = (a == 4 + F + d);
        if (a == 0)               e_st = 3'd0;
        else if (e_sc)            e_st = 3'd1;
        else if (e_lw)            e_st = 3'd2;
        else if (e_sv)            e_st = 3'd3;
        else if (a <= 2 + F + d)  e_st = 3'd4;
        else if (e_cap)           e_st = 3'd5;
        else                      e_st = 3'd6;
        e_jd = 8'(jobs[i] & jmask(i));
        return {e_sc, e_lw, e_sv, e_cap, e_bsy, e_dn, abt[i], e_st, e_jd};
    endfunction

    function automatic logic [17:0] obs_vec(input int i);
        logic [7:0] j;
        j = (i == 0) ? jd0 : ((i == 1) ? {6'b0, jd1} : jd2);
        return {sc[i], lw[i], sv[i], cap[i], bsy[i], dn[i], ab[i], st[i], j};
    endfunction

    // One clock of stimulus; all three instances are compared to the model.
    task automatic step(input logic s, input logic a, input string tag);
        start = s;
        abort = a;
        @(posedge clk);
        model_update(s, a);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs_vec(i) !== exp_vec(i)) begin
                n_bad++;
                $display("FAIL %s dut%0d: got %h expected %h", tag, i, obs_vec(i), exp_vec(i));
            end
        end
        $display("step %s start=%0b abort=%0b st0=%0d jd0=%0d", tag, s, a, st[0], jd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs_vec(i) !== 18'h0) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: got %h expected 0", i, obs_vec(i));
            end
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1'b0, 1'b1, "idle_abort");
        n_cmp++;
        if (ab[0] !== 1'b0 || st[0] !== 3'd0) begin
            n_bad++;
            $display("FAIL idle_abort: got aborted=%0b state=%0d expected 0/0", ab[0], st[0]);
        end
    endtask

    task automatic test_single_job();
        int clr_at = -1, lw_at = -1, first_v = -1, vcnt = 0, cap_at = -1;
        int done_at = -1, done2_at = -1, bcnt = 0;
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            step(c == 1, 1'b0, "single");
            if (sc[0]) clr_at = c;
            if (lw[0]) lw_at = c;
            if (sv[0]) begin
                vcnt++;
                if (first_v < 0) first_v = c;
            end
            if (cap[0]) cap_at = c;
            if (dn[0]) done_at = c;
            if (dn[2]) done2_at = c;
            if (bsy[0]) bcnt++;
        end
        n_cmp++; if (clr_at !== 1) begin n_bad++; $display("FAIL clear_cycle: got %0d expected 1", clr_at); end
        n_cmp++; if (lw_at !== 2) begin n_bad++; $display("FAIL load_cycle: got %0d expected 2", lw_at); end
        n_cmp++; if (first_v !== 3 || vcnt !== 3) begin n_bad++; $display("FAIL valid_window: got first=%0d count=%0d expected 3/3", first_v, vcnt); end
        n_cmp++; if (cap_at !== 8) begin n_bad++; $display("FAIL capture_cycle: got %0d expected 8", cap_at); end
        n_cmp++; if (done_at !== 9) begin n_bad++; $display("FAIL done_cycle: got %0d expected 9", done_at); end
        n_cmp++; if (bcnt !== 8) begin n_bad++; $display("FAIL busy_cycles: got %0d expected 8", bcnt); end
        n_cmp++; if (jd0 !== 8'd1) begin n_bad++; $display("FAIL single_jobs: got %0d expected 1", jd0); end
        n_cmp++; if (done2_at !== 8) begin n_bad++; $display("FAIL drain1_done_cycle: got %0d expected 8", done2_at); end
    endtask

    task automatic test_back_to_back();
        int dcnt = 0, vcnt = 0;
        bit gap = 1'b0;
        do_reset();
        for (int c = 1; c <= 32; c++) begin
            step(c <= 27, 1'b0, "b2b");
            if (dn[0]) dcnt++;
            if (sv[0]) vcnt++;
            if (c <= 27 && st[0] == 3'd0) gap = 1'b1;
        end
        n_cmp++; if (dcnt !== 3) begin n_bad++; $display("FAIL b2b_dones: got %0d expected 3", dcnt); end
        n_cmp++; if (vcnt !== 9) begin n_bad++; $display("FAIL b2b_valids: got %0d expected 9", vcnt); end
        n_cmp++; if (gap !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap: got %0b expected 0", gap); end
        n_cmp++; if (jd0 !== 8'd3) begin n_bad++; $display("FAIL b2b_jobs: got %0d expected 3", jd0); end
    endtask

    task automatic test_start_ignored();
        int dcnt = 0;
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            step(c == 1 || c == 5 || c == 7, 1'b0, "busy_start");
            if (dn[0]) dcnt++;
        end
        n_cmp++; if (dcnt !== 1) begin n_bad++; $display("FAIL busy_start_dones: got %0d expected 1", dcnt); end
        n_cmp++; if (jd0 !== 8'd1) begin n_bad++; $display("FAIL busy_start_jobs: got %0d expected 1", jd0); end
    endtask

    task automatic test_abort_feed();
        int acnt = 0, ccnt = 0, dcnt = 0;
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            step(c == 1, c == 5, "abort_feed");
            if (c == 5) begin
                n_cmp++;
                if (sv[0] !== 1'b0 || st[0] !== 3'd0 || ab[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL abort_feed_next: got valid=%0b state=%0d aborted=%0b expected 0/0/1", sv[0], st[0], ab[0]);
                end
            end
            if (ab[0]) acnt++;
            if (cap[0]) ccnt++;
            if (dn[0]) dcnt++;
        end
        n_cmp++; if (acnt !== 1) begin n_bad++; $display("FAIL abort_feed_pulses: got %0d expected 1", acnt); end
        n_cmp++; if (ccnt !== 0 || dcnt !== 0) begin n_bad++; $display("FAIL abort_feed_finish: got capture=%0d done=%0d expected 0/0", ccnt, dcnt); end
        n_cmp++; if (jd0 !== 8'd0) begin n_bad++; $display("FAIL abort_feed_jobs: got %0d expected 0", jd0); end
    endtask

    task automatic test_abort_capture();
        int dcnt = 0;
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            step(c == 1, c == 9, "abort_cap");
            if (c == 9) begin
                n_cmp++;
                if (st[0] !== 3'd0 || ab[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL abort_cap_next: got state=%0d aborted=%0b expected 0/1", st[0], ab[0]);
                end
            end
            if (dn[0]) dcnt++;
        end
        n_cmp++; if (dcnt !== 0) begin n_bad++; $display("FAIL abort_cap_done: got %0d expected 0", dcnt); end
        n_cmp++; if (jd0 !== 8'd0) begin n_bad++; $display("FAIL abort_cap_jobs: got %0d expected 0", jd0); end
        // The DRAIN_CYCLES=1 instance is in DONE when abort arrives, so it finishes.
        n_cmp++; if (jd2 !== 8'd1) begin n_bad++; $display("FAIL abort_in_done_jobs: got %0d expected 1", jd2); end
    endtask

    task automatic test_async_reset();
        int done_at = -1;
        do_reset();
        for (int c = 1; c <= 6; c++) step(c == 1, 1'b0, "pre_reset");
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs_vec(i) !== 18'h0) begin
                n_bad++;
                $display("FAIL async_reset dut%0d: got %h expected 0", i, obs_vec(i));
            end
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            step(c == 1, 1'b0, "post_reset");
            if (dn[0]) done_at = c;
        end
        n_cmp++; if (done_at !== 9) begin n_bad++; $display("FAIL post_reset_done: got %0d expected 9", done_at); end
        n_cmp++; if (jd0 !== 8'd1) begin n_bad++; $display("FAIL post_reset_jobs: got %0d expected 1", jd0); end
    endtask

    task automatic test_wrap();
        bit saw_wrap = 1'b0;
        logic [1:0] prev = 2'd0;
        do_reset();
        for (int c = 1; c <= 47; c++) begin
            step(c <= 45, 1'b0, "wrap");
            if (prev == 2'd3 && jd1 == 2'd0) saw_wrap = 1'b1;
            prev = jd1;
        end
        n_cmp++; if (saw_wrap !== 1'b1) begin n_bad++; $display("FAIL wrap_seen: got %0b expected 1", saw_wrap); end
        n_cmp++; if (jd1 !== 2'd1) begin n_bad++; $display("FAIL wrap_jobs: got %0d expected 1", jd1); end
        n_cmp++; if (jd0 !== 8'd5) begin n_bad++; $display("FAIL wrap_ref_jobs: got %0d expected 5", jd0); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_job();
        test_back_to_back();
        test_start_ignored();
        test_abort_feed();
        test_abort_capture();
        test_async_reset();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
